// File: rtl/npu_pkg.sv
// Shared conv-NPU constants and the instruction-generator FSM state encoding.
package npu_pkg;

  localparam int CSR_AW  = 32;
  localparam int XLEN    = 32;
  localparam int FRAM_AW = 20;
  localparam int KRAM_AW = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    GEN
  } state_t;

endpackage

// File: rtl/instgen_cnt2d.sv
// 2-D raster counter for output pixels (ox fastest), with row-wrap and
// "next position is the final pixel" flags for registered tlast generation.
module instgen_cnt2d #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_adv,
  input  logic [W-1:0] i_width,
  input  logic [W-1:0] i_height,
  output logic         o_last_x,
  output logic         o_next_last
);

  logic [W-1:0] r_x;
  logic [W-1:0] r_y;
  logic         w_last_y;

  assign o_last_x = (r_x == i_width - 1'b1);
  assign w_last_y = (r_y == i_height - 1'b1);
  assign o_next_last = o_last_x ? ((r_y + 1'b1 == i_height - 1'b1) && (i_width == 1))
                                : (w_last_y && (r_x + 1'b1 == i_width - 1'b1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (o_last_x) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instgen.sv
// Conv-layer instruction generator: one descriptor in, one instruction per output pixel out.
// Define INSTGEN_ASSERT_EN to compile in simulation assertions on the instruction stream.
module instgen
  import npu_pkg::*;
#(
  parameter int ADDR_WIDTH      = CSR_AW,
  parameter int DATA_WIDTH      = XLEN,
  parameter int FRAM_ADDR_WIDTH = FRAM_AW,
  parameter int KRAM_ADDR_WIDTH = KRAM_AW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_WIDTH-1:0]      feature_baseaddr,
  input  logic [ADDR_WIDTH-1:0]      kernel_baseaddr,
  input  logic [ADDR_WIDTH-1:0]      output_baseaddr,
  input  logic [DATA_WIDTH-1:0]      feature_width,
  input  logic [DATA_WIDTH-1:0]      feature_height,
  input  logic [DATA_WIDTH-1:0]      feature_chin,
  input  logic [DATA_WIDTH-1:0]      feature_chout,
  input  logic [DATA_WIDTH-1:0]      output_width,
  input  logic [DATA_WIDTH-1:0]      output_height,
  input  logic [7:0]                 kernel_sizeh,
  input  logic [7:0]                 kernel_sizew,
  input  logic [7:0]                 stride,
  input  logic                       has_bias,
  input  logic                       has_relu,
  input  logic                       csrcmd_valid,
  output logic                       instgen_ready,
  output logic [FRAM_ADDR_WIDTH-1:0] stride_feature_baseaddr,
  output logic [KRAM_ADDR_WIDTH-1:0] stride_kernel_baseaddr,
  output logic [DATA_WIDTH-1:0]      stride_feature_chin,
  output logic [DATA_WIDTH-1:0]      stride_feature_chout,
  output logic [DATA_WIDTH-1:0]      stride_feature_width,
  output logic [DATA_WIDTH-1:0]      stride_feature_height,
  output logic [7:0]                 stride_kernel_sizeh,
  output logic [7:0]                 stride_kernel_sizew,
  output logic                       stride_has_bias,
  output logic                       stride_has_relu,
  output logic [FRAM_ADDR_WIDTH-1:0] stride_wb_baseaddr,
  output logic [DATA_WIDTH-1:0]      stride_wb_ch_offset,
  output logic                       inst_valid,
  output logic                       tlast,
  input  logic                       decoder_ready
);

  state_t                     r_state;
  logic [DATA_WIDTH-1:0]      r_ow;
  logic [DATA_WIDTH-1:0]      r_oh;
  logic [7:0]                 r_stride;
  logic [FRAM_ADDR_WIDTH-1:0] r_xstep;
  logic [FRAM_ADDR_WIDTH-1:0] r_ystep;
  logic [FRAM_ADDR_WIDTH-1:0] r_frow;
  logic [FRAM_ADDR_WIDTH-1:0] r_wbrow;

  logic [DATA_WIDTH-1:0]      w_s;
  logic [FRAM_ADDR_WIDTH-1:0] w_xstep;
  logic [FRAM_ADDR_WIDTH-1:0] w_ystep;
  logic [FRAM_ADDR_WIDTH-1:0] w_ow_f;
  logic                       w_cnt_load;
  logic                       w_cnt_adv;
  logic                       w_last_x;
  logic                       w_next_last;
  logic                       w_unused;

  // A zero stride behaves as 1; only low address bits matter, so the products are truncated early.
  assign w_s     = (r_stride == 8'd0) ? DATA_WIDTH'(1) : DATA_WIDTH'(r_stride);
  assign w_xstep = FRAM_ADDR_WIDTH'(w_s * stride_feature_chin);
  assign w_ystep = FRAM_ADDR_WIDTH'(w_s * stride_feature_width * stride_feature_chin);
  assign w_ow_f  = r_ow[FRAM_ADDR_WIDTH-1:0];

  assign w_cnt_load = (r_state == SETUP);
  assign w_cnt_adv  = (r_state == GEN) && decoder_ready && !tlast;
  assign w_unused   = ^{feature_baseaddr[ADDR_WIDTH-1:FRAM_ADDR_WIDTH],
                        output_baseaddr[ADDR_WIDTH-1:FRAM_ADDR_WIDTH],
                        kernel_baseaddr[ADDR_WIDTH-1:KRAM_ADDR_WIDTH]};

  instgen_cnt2d #(.W(DATA_WIDTH)) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_cnt_load),
    .i_adv       (w_cnt_adv),
    .i_width     (r_ow),
    .i_height    (r_oh),
    .o_last_x    (w_last_x),
    .o_next_last (w_next_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state                 <= IDLE;
      instgen_ready           <= 1'b1;
      inst_valid              <= 1'b0;
      tlast                   <= 1'b0;
      r_ow                    <= '0;
      r_oh                    <= '0;
      r_stride                <= '0;
      r_xstep                 <= '0;
      r_ystep                 <= '0;
      r_frow                  <= '0;
      r_wbrow                 <= '0;
      stride_feature_baseaddr <= '0;
      stride_kernel_baseaddr  <= '0;
      stride_feature_chin     <= '0;
      stride_feature_chout    <= '0;
      stride_feature_width    <= '0;
      stride_feature_height   <= '0;
      stride_kernel_sizeh     <= '0;
      stride_kernel_sizew     <= '0;
      stride_has_bias         <= 1'b0;
      stride_has_relu         <= 1'b0;
      stride_wb_baseaddr      <= '0;
      stride_wb_ch_offset     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (csrcmd_valid) begin
            r_state                 <= SETUP;
            instgen_ready           <= 1'b0;
            r_ow                    <= output_width;
            r_oh                    <= output_height;
            r_stride                <= stride;
            r_frow                  <= feature_baseaddr[FRAM_ADDR_WIDTH-1:0];
            r_wbrow                 <= output_baseaddr[FRAM_ADDR_WIDTH-1:0];
            stride_feature_baseaddr <= feature_baseaddr[FRAM_ADDR_WIDTH-1:0];
            stride_wb_baseaddr      <= output_baseaddr[FRAM_ADDR_WIDTH-1:0];
            stride_kernel_baseaddr  <= kernel_baseaddr[KRAM_ADDR_WIDTH-1:0];
            stride_feature_chin     <= feature_chin;
            stride_feature_chout    <= feature_chout;
            stride_feature_width    <= feature_width;
            stride_feature_height   <= feature_height;
            stride_kernel_sizeh     <= kernel_sizeh;
            stride_kernel_sizew     <= kernel_sizew;
            stride_has_bias         <= has_bias;
            stride_has_relu         <= has_relu;
          end
        end
        SETUP: begin
          r_xstep             <= w_xstep;
          r_ystep             <= w_ystep;
          stride_wb_ch_offset <= r_ow * r_oh;
          if (r_ow == '0 || r_oh == '0) begin
            r_state       <= IDLE;
            instgen_ready <= 1'b1;
          end else begin
            r_state    <= GEN;
            inst_valid <= 1'b1;
            tlast      <= (r_ow == 1) && (r_oh == 1);
          end
        end
        GEN: begin
          if (decoder_ready) begin
            if (tlast) begin
              r_state       <= IDLE;
              instgen_ready <= 1'b1;
              inst_valid    <= 1'b0;
              tlast         <= 1'b0;
            end else begin
              tlast <= w_next_last;
              // Row wrap restarts from the row pointer, so no per-pixel multiply is needed.
              if (w_last_x) begin
                r_frow                  <= r_frow + r_ystep;
                stride_feature_baseaddr <= r_frow + r_ystep;
                r_wbrow                 <= r_wbrow + w_ow_f;
                stride_wb_baseaddr      <= r_wbrow + w_ow_f;
              end else begin
                stride_feature_baseaddr <= stride_feature_baseaddr + r_xstep;
                stride_wb_baseaddr      <= stride_wb_baseaddr + 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef INSTGEN_ASSERT_EN
  logic [DATA_WIDTH-1:0] a_xfers;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         a_xfers <= '0;
    else if (r_state == SETUP)          a_xfers <= '0;
    else if (inst_valid && decoder_ready) a_xfers <= a_xfers + 1'b1;
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    inst_valid && !decoder_ready |=> inst_valid && $stable(stride_feature_baseaddr)
      && $stable(stride_wb_baseaddr) && $stable(tlast));

  a_tlast_final: assert property (@(posedge clk) disable iff (!rst_n)
    inst_valid |-> (tlast == (a_xfers + 1'b1 == stride_wb_ch_offset)));

  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == IDLE) |-> !inst_valid);
`endif

endmodule

// File: tb/tb_instgen.sv
// Self-checking bench for instgen: scoreboard of expected instructions plus a table of spot vectors.
module tb_instgen;

  logic        clk;
  logic        rst_n;
  logic [31:0] feature_baseaddr, kernel_baseaddr, output_baseaddr;
  logic [31:0] feature_width, feature_height, feature_chin, feature_chout;
  logic [31:0] output_width, output_height;
  logic [7:0]  kernel_sizeh, kernel_sizew, stride;
  logic        has_bias, has_relu, csrcmd_valid, instgen_ready;
  logic [19:0] stride_feature_baseaddr;
  logic [15:0] stride_kernel_baseaddr;
  logic [31:0] stride_feature_chin, stride_feature_chout, stride_feature_width, stride_feature_height;
  logic [7:0]  stride_kernel_sizeh, stride_kernel_sizew;
  logic        stride_has_bias, stride_has_relu;
  logic [19:0] stride_wb_baseaddr;
  logic [31:0] stride_wb_ch_offset;
  logic        inst_valid, tlast, decoder_ready;

  instgen dut (
    .clk(clk), .rst_n(rst_n),
    .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
    .output_baseaddr(output_baseaddr),
    .feature_width(feature_width), .feature_height(feature_height),
    .feature_chin(feature_chin), .feature_chout(feature_chout),
    .output_width(output_width), .output_height(output_height),
    .kernel_sizeh(kernel_sizeh), .kernel_sizew(kernel_sizew), .stride(stride),
    .has_bias(has_bias), .has_relu(has_relu),
    .csrcmd_valid(csrcmd_valid), .instgen_ready(instgen_ready),
    .stride_feature_baseaddr(stride_feature_baseaddr),
    .stride_kernel_baseaddr(stride_kernel_baseaddr),
    .stride_feature_chin(stride_feature_chin), .stride_feature_chout(stride_feature_chout),
    .stride_feature_width(stride_feature_width), .stride_feature_height(stride_feature_height),
    .stride_kernel_sizeh(stride_kernel_sizeh), .stride_kernel_sizew(stride_kernel_sizew),
    .stride_has_bias(stride_has_bias), .stride_has_relu(stride_has_relu),
    .stride_wb_baseaddr(stride_wb_baseaddr), .stride_wb_ch_offset(stride_wb_ch_offset),
    .inst_valid(inst_valid), .tlast(tlast), .decoder_ready(decoder_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fbase, kbase, obase, fw, fh, chin, chout, ow, oh;
    logic [7:0]  kh, kw, s;
    logic        bias, relu;
  } desc_t;

  typedef struct {
    logic [19:0] feat;
    logic [19:0] wb;
    logic        last;
  } inst_t;

  typedef struct {
    int          key;
    int          idx;
    logic [19:0] feat;
    logic [19:0] wb;
    logic        last;
  } spot_t;

  inst_t exp_q[$];
  inst_t log_q[$];
  desc_t cur;
  int    n_xfer;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic desc_t mk(input logic [31:0] fbase, kbase, obase, fw, fh, chin, chout,
                               ow, oh, input logic [7:0] s, input logic bias, relu);
    desc_t d;
    d.fbase = fbase; d.kbase = kbase; d.obase = obase;
    d.fw = fw; d.fh = fh; d.chin = chin; d.chout = chout;
    d.ow = ow; d.oh = oh; d.kh = 8'd3; d.kw = 8'd3; d.s = s;
    d.bias = bias; d.relu = relu;
    return d;
  endfunction

  task automatic drive_desc(input desc_t d);
    feature_baseaddr = d.fbase; kernel_baseaddr = d.kbase; output_baseaddr = d.obase;
    feature_width = d.fw; feature_height = d.fh; feature_chin = d.chin; feature_chout = d.chout;
    output_width = d.ow; output_height = d.oh;
    kernel_sizeh = d.kh; kernel_sizew = d.kw; stride = d.s;
    has_bias = d.bias; has_relu = d.relu;
  endtask

  // Reference addresses straight from the memory-layout formulas.
  task automatic push_expected(input desc_t d);
    logic [31:0] s;
    logic [31:0] fa, wa;
    inst_t e;
    s = (d.s == 8'd0) ? 32'd1 : {24'd0, d.s};
    for (int unsigned oy = 0; oy < d.oh; oy++) begin
      for (int unsigned ox = 0; ox < d.ow; ox++) begin
        fa = d.fbase + (oy * s * d.fw + ox * s) * d.chin;
        wa = d.obase + oy * d.ow + ox;
        e.feat = fa[19:0];
        e.wb   = wa[19:0];
        e.last = (oy == d.oh - 1) && (ox == d.ow - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && inst_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst_valid", inst_valid, 1'b0);
      end else begin
        check("feature_addr", stride_feature_baseaddr, exp_q[0].feat);
        check("wb_addr", stride_wb_baseaddr, exp_q[0].wb);
        check("tlast", tlast, exp_q[0].last);
        if (decoder_ready) begin
          check("passthru",
                {stride_feature_chin, stride_feature_chout, stride_feature_width,
                 stride_feature_height, stride_kernel_sizeh, stride_kernel_sizew,
                 stride_has_bias, stride_has_relu, stride_kernel_baseaddr, stride_wb_ch_offset},
                {cur.chin, cur.chout, cur.fw, cur.fh, cur.kh, cur.kw, cur.bias, cur.relu,
                 cur.kbase[15:0], 32'(cur.ow * cur.oh)});
          log_q.push_back('{feat: stride_feature_baseaddr, wb: stride_wb_baseaddr, last: tlast});
          void'(exp_q.pop_front());
          n_xfer++;
        end
      end
    end
  end

  spot_t spots[10];

  // mode 0: ready=1, 1: ready toggles, 2: descriptor pulse during GEN, 3: reset after 50 transfers
  task automatic run_layer(input desc_t d, input int mode, input int key);
    desc_t junk;
    int    cyc;
    junk = mk(32'h5555, 32'h7777, 32'h9999, 32'd7, 32'd7, 32'd9, 32'd1, 32'd2, 32'd2, 8'd3, 1'b0, 1'b1);
    n_xfer = 0;
    exp_q.delete();
    log_q.delete();
    cur = d;
    check("ready_before_desc", instgen_ready, 1'b1);
    @(posedge clk); #1;
    decoder_ready = (mode != 1);
    drive_desc(d);
    csrcmd_valid = 1'b1;
    push_expected(d);
    @(posedge clk); #1;
    csrcmd_valid = 1'b0;
    @(negedge clk);
    check("setup_no_valid", inst_valid, 1'b0);
    check("setup_not_ready", instgen_ready, 1'b0);
    @(negedge clk);
    if (d.ow * d.oh != 0) begin
      check("first_valid_latency", inst_valid, 1'b1);
    end else begin
      check("empty_no_valid", inst_valid, 1'b0);
      check("empty_ready_back", instgen_ready, 1'b1);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000 && !(mode == 3 && n_xfer >= 50)) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 1) decoder_ready = ~decoder_ready;
      if (mode == 2 && cyc == 5) begin drive_desc(junk); csrcmd_valid = 1'b1; end
      if (mode == 2 && cyc == 6) begin csrcmd_valid = 1'b0; drive_desc(d); end
    end
    if (mode == 3) begin
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_valid", inst_valid, 1'b0);
      check("rst_mid_ready", instgen_ready, 1'b1);
      check("rst_mid_outputs", {tlast, stride_feature_baseaddr, stride_wb_baseaddr, stride_wb_ch_offset}, '0);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
    end else begin
      if (cyc >= 4000) check("layer_timeout", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      check("done_ready", instgen_ready, 1'b1);
      check("done_no_valid", inst_valid, 1'b0);
      check("xfer_count", n_xfer, d.ow * d.oh);
      foreach (spots[i]) begin
        if (spots[i].key == key) begin
          if (spots[i].idx < log_q.size()) begin
            check($sformatf("spot%0d_%0d", key, spots[i].idx),
                  {log_q[spots[i].idx].feat, log_q[spots[i].idx].wb, log_q[spots[i].idx].last},
                  {spots[i].feat, spots[i].wb, spots[i].last});
          end else begin
            check("spot_present", log_q.size() > spots[i].idx, 1'b1);
          end
        end
      end
    end
  endtask

  initial begin
    desc_t la, ls2, lw, lz;
    spots[0] = '{0,   0, 20'h00000, 20'h10000, 1'b0};
    spots[1] = '{0,   1, 20'h00003, 20'h10001, 1'b0};
    spots[2] = '{0,  18, 20'd60,    20'h10012, 1'b0};
    spots[3] = '{0, 143, 20'h001D7, 20'h1008F, 1'b1};
    spots[4] = '{1,   0, 20'h00000, 20'h02000, 1'b0};
    spots[5] = '{1,   1, 20'h00006, 20'h02001, 1'b0};
    spots[6] = '{1,   9, 20'd120,   20'h02009, 1'b0};
    spots[7] = '{1,  35, 20'd408,   20'h02023, 1'b1};
    spots[8] = '{2,   0, 20'hFFFF0, 20'hFFFFE, 1'b0};
    spots[9] = '{2,   5, 20'h0000C, 20'h00003, 1'b1};

    la  = mk(32'h0, 32'h0, 32'h10000, 32'd20, 32'd10, 32'd3, 32'd32, 32'd18, 32'd8, 8'd1, 1'b1, 1'b1);
    ls2 = mk(32'h0, 32'h1234, 32'h2000, 32'd20, 32'd10, 32'd3, 32'd16, 32'd9, 32'd4, 8'd2, 1'b0, 1'b1);
    lw  = mk(32'hFFFF_FFF0, 32'hABCD_5678, 32'h000F_FFFE, 32'd5, 32'd4, 32'd4, 32'd8, 32'd3, 32'd2,
             8'd0, 1'b1, 1'b0);
    lz  = mk(32'h100, 32'h0, 32'h200, 32'd20, 32'd10, 32'd3, 32'd32, 32'd0, 32'd8, 8'd1, 1'b0, 1'b0);

    rst_n = 1'b0;
    csrcmd_valid = 1'b0;
    decoder_ready = 1'b1;
    drive_desc(la);
    #12;
    check("reset_ready", instgen_ready, 1'b1);
    check("reset_outputs", {inst_valid, tlast, stride_feature_baseaddr, stride_wb_baseaddr,
                            stride_wb_ch_offset, stride_kernel_baseaddr, stride_feature_chin}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_layer(la, 0, 0);
    run_layer(la, 1, 0);
    run_layer(ls2, 0, 1);
    run_layer(lw, 0, 2);
    run_layer(lz, 0, -1);
    run_layer(la, 2, 0);
    run_layer(la, 3, -1);
    run_layer(la, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
